// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the two requester ports and the data-memory port around the
// arbiter. The arbiter uses the slave view. The load/store unit, the DMA
// engine and the memory model together use the master view.
interface dmem_port_arbiter_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  // core load/store port
  logic                  c_req;
  logic                  c_we;
  logic [DM_ADDRESS-1:0] c_addr;
  logic [DATA_W-1:0]     c_wdata;
  logic [3:0]            c_be;
  logic                  c_gnt;
  logic                  c_rvalid;
  logic [DATA_W-1:0]     c_rdata;

  // DMA/debug port
  logic                  d_req;
  logic                  d_we;
  logic [DM_ADDRESS-1:0] d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [3:0]            d_be;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_W-1:0]     d_rdata;

  // data-memory port
  logic [DM_ADDRESS-1:0] mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [3:0]            mem_wr;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata, c_be,
    output c_gnt, c_rvalid, c_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_gnt, d_rvalid, d_rdata,
    output mem_addr, mem_wdata, mem_wr,
    input  mem_rdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata, c_be,
    input  c_gnt, c_rvalid, c_rdata,
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_addr, mem_wdata, mem_wr,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of the single data-memory port. The core has
// fixed priority, and an aging counter guarantees the DMA a grant once it has
// lost DMA_MAX_WAIT cycles in a row. Each grant registers one word-addressed
// access. Acknowledgement follows two cycles after the grant.
//
// state  | meaning
// -------+-------------------------------------------------------
// IDLE   | no access in flight, arbitrating
// ACCESS | registered access on the memory port, no grants
// RESP   | rvalid to the owning port, arbitrating for the next access
module dmem_port_arbiter #(
  parameter int DM_ADDRESS   = 9,
  parameter int DATA_W       = 32,
  parameter int DMA_MAX_WAIT = 4
) (
  input logic               clk,
  input logic               rst_n,
  dmem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam int                    WAIT_W    = $clog2(DMA_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0]     WAIT_MAX  = WAIT_W'(DMA_MAX_WAIT);
  localparam logic [DM_ADDRESS-1:0] WORD_MASK = {{(DM_ADDRESS-2){1'b1}}, 2'b00};

  state_e                state_q, state_d;
  logic [WAIT_W-1:0]     dma_wait_q, dma_wait_d;
  logic [DM_ADDRESS-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic [3:0]            strobe_q, strobe_d;
  logic                  port_q, port_d;      // 0 = core, 1 = DMA
  logic                  is_wr_q, is_wr_d;
  logic [DATA_W-1:0]     c_rdata_q, c_rdata_d;
  logic [DATA_W-1:0]     d_rdata_q, d_rdata_d;

  logic arb_en;
  logic dma_aged;
  logic c_win;
  logic d_win;

  // Winner selection. Grants are gated by reset so none appear while rst_n is low.
  always_comb begin
    c_win    = 1'b0;
    d_win    = 1'b0;
    arb_en   = rst_n && (state_q != ST_ACCESS);
    dma_aged = (dma_wait_q == WAIT_MAX);
    if (arb_en) begin
      d_win = bus.d_req && (!bus.c_req || dma_aged);
      c_win = bus.c_req && !d_win;
    end
  end

  // Next state, request latching, read capture and the DMA aging counter.
  always_comb begin
    state_d     = state_q;
    dma_wait_d  = dma_wait_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    strobe_d    = strobe_q;
    port_d      = port_q;
    is_wr_d     = is_wr_q;
    c_rdata_d   = c_rdata_q;
    d_rdata_d   = d_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (c_win || d_win) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        // A write acknowledges with zero data rather than whatever the memory returns.
        if (port_q) d_rdata_d = is_wr_q ? '0 : bus.mem_rdata;
        else        c_rdata_d = is_wr_q ? '0 : bus.mem_rdata;
      end
      ST_RESP: begin
        state_d = (c_win || d_win) ? ST_ACCESS : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (d_win) begin
      mem_addr_d  = bus.d_addr & WORD_MASK;
      mem_wdata_d = bus.d_wdata;
      strobe_d    = bus.d_we ? bus.d_be : 4'b0000;
      is_wr_d     = bus.d_we;
      port_d      = 1'b1;
    end else if (c_win) begin
      mem_addr_d  = bus.c_addr & WORD_MASK;
      mem_wdata_d = bus.c_wdata;
      strobe_d    = bus.c_we ? bus.c_be : 4'b0000;
      is_wr_d     = bus.c_we;
      port_d      = 1'b0;
    end

    // The counter also runs during ACCESS, so time spent behind a core access counts.
    if (d_win) begin
      dma_wait_d = '0;
    end else if (bus.d_req && (dma_wait_q != WAIT_MAX)) begin
      dma_wait_d = dma_wait_q + WAIT_W'(1);
    end
  end

  // State and datapath registers. Reset drops any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      dma_wait_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      strobe_q    <= 4'b0000;
      port_q      <= 1'b0;
      is_wr_q     <= 1'b0;
      c_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      dma_wait_q  <= dma_wait_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      strobe_q    <= strobe_d;
      port_q      <= port_d;
      is_wr_q     <= is_wr_d;
      c_rdata_q   <= c_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign bus.c_gnt     = c_win;
  assign bus.d_gnt     = d_win;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wr    = (state_q == ST_ACCESS) ? strobe_q : 4'b0000;
  assign bus.c_rvalid  = (state_q == ST_RESP) && !port_q;
  assign bus.d_rvalid  = (state_q == ST_RESP) && port_q;
  assign bus.c_rdata   = c_rdata_q;
  assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized bench for dmem_port_arbiter. A transaction-level model predicts
// grants, memory-port activity and responses cycle by cycle.
module tb_dmem_port_arbiter;
  localparam int AW   = 9;
  localparam int DW   = 32;
  localparam int MAXW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.DM_ADDRESS(AW), .DATA_W(DW)) bus ();

  dmem_port_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW), .DMA_MAX_WAIT(MAXW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // memory environment; written from the main process only
  logic [31:0] tb_mem  [128];
  logic [31:0] ref_mem [128];
  assign bus.mem_rdata = tb_mem[bus.mem_addr[AW-1:2]];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    be;
  } req_t;

  req_t c_cur, d_cur;
  bit   c_pend, d_pend;

  // model state
  bit          m_gnt_prev;
  int          m_wait;
  req_t        m_acc;
  bit          m_acc_port;
  bit          m_resp_v;
  bit          m_resp_port;
  logic [31:0] m_resp_data;
  logic [31:0] m_last [2];

  task automatic model_reset();
    m_gnt_prev = 0;
    m_wait     = 0;
    m_resp_v   = 0;
    m_last[0]  = '0;
    m_last[1]  = '0;
  endtask

  task automatic drive();
    bus.c_req   = c_pend;
    bus.c_we    = c_cur.we;
    bus.c_addr  = c_cur.addr;
    bus.c_wdata = c_cur.wdata;
    bus.c_be    = c_cur.be;
    bus.d_req   = d_pend;
    bus.d_we    = d_cur.we;
    bus.d_addr  = d_cur.addr;
    bus.d_wdata = d_cur.wdata;
    bus.d_be    = d_cur.be;
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.we    = 1'($urandom_range(0, 1));
    r.addr  = AW'($urandom);
    r.wdata = $urandom;
    r.be    = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom);
    return r;
  endfunction

  task automatic gen(input int pct);
    if (!c_pend && $urandom_range(0, 99) < pct) begin c_cur = rand_req(); c_pend = 1; end
    if (!d_pend && $urandom_range(0, 99) < pct) begin d_cur = rand_req(); d_pend = 1; end
    drive();
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // One clock cycle: compare at the falling edge, advance the model, then drop granted requests.
  task automatic step();
    bit          cw, dw, cur_v, cur_p;
    logic [31:0] cur_d;
    int          word;
    @(negedge clk);
    cw = 0;
    dw = 0;
    if (!m_gnt_prev) begin
      if (c_pend && d_pend) begin
        if (m_wait == MAXW) dw = 1; else cw = 1;
      end else if (c_pend) cw = 1;
      else if (d_pend)     dw = 1;
    end
    check("c_gnt", bus.c_gnt, cw);
    check("d_gnt", bus.d_gnt, dw);

    cur_v = m_resp_v;
    cur_p = m_resp_port;
    cur_d = m_resp_data;
    m_resp_v = 0;
    if (m_gnt_prev) begin
      word = int'(m_acc.addr[AW-1:2]);
      check("mem_addr", bus.mem_addr, {m_acc.addr[AW-1:2], 2'b00});
      check("mem_wr", bus.mem_wr, m_acc.we ? m_acc.be : 4'h0);
      if (m_acc.we) check("mem_wdata", bus.mem_wdata, m_acc.wdata);
      m_resp_data = m_acc.we ? 32'h0 : ref_mem[word];
      if (m_acc.we)
        for (int i = 0; i < 4; i++)
          if (m_acc.be[i]) ref_mem[word][8*i +: 8] = m_acc.wdata[8*i +: 8];
      m_resp_v    = 1;
      m_resp_port = m_acc_port;
    end else begin
      check("mem_wr_quiet", bus.mem_wr, 4'h0);
    end

    if (cur_v) m_last[cur_p] = cur_d;
    check("c_rvalid", bus.c_rvalid, cur_v && !cur_p);
    check("d_rvalid", bus.d_rvalid, cur_v && cur_p);
    check("c_rdata", bus.c_rdata, m_last[0]);
    check("d_rdata", bus.d_rdata, m_last[1]);

    if (bus.mem_wr != 4'h0)
      for (int i = 0; i < 4; i++)
        if (bus.mem_wr[i]) tb_mem[bus.mem_addr[AW-1:2]][8*i +: 8] = bus.mem_wdata[8*i +: 8];

    if (dw) m_wait = 0;
    else if (d_pend && m_wait < MAXW) m_wait++;
    if (cw) begin m_acc = c_cur; m_acc_port = 0; end
    if (dw) begin m_acc = d_cur; m_acc_port = 1; end
    m_gnt_prev = cw || dw;

    @(posedge clk);
    #1;
    if (cw) c_pend = 0;
    if (dw) d_pend = 0;
    drive();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_addr"}, bus.mem_addr, '0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, '0);
    check({tag, "_mem_wr"}, bus.mem_wr, 4'h0);
    check({tag, "_c_rvalid"}, bus.c_rvalid, 1'b0);
    check({tag, "_d_rvalid"}, bus.d_rvalid, 1'b0);
    check({tag, "_c_rdata"}, bus.c_rdata, '0);
    check({tag, "_d_rdata"}, bus.d_rdata, '0);
  endtask

  task automatic check_gnt_in_reset(input string tag);
    c_pend = 1;
    d_pend = 1;
    c_cur  = rand_req();
    d_cur  = rand_req();
    drive();
    #1;
    check({tag, "_c_gnt"}, bus.c_gnt, 1'b0);
    check({tag, "_d_gnt"}, bus.d_gnt, 1'b0);
    c_pend = 0;
    d_pend = 0;
    drive();
  endtask

  initial begin
    logic [31:0] v;
    int          guard;
    for (int i = 0; i < 128; i++) begin
      v = $urandom;
      tb_mem[i]  = v;
      ref_mem[i] = v;
    end
    c_pend = 0;
    d_pend = 0;
    c_cur  = rand_req();
    d_cur  = rand_req();
    drive();
    model_reset();

    #2;
    check_reset_outputs("rst");
    check_gnt_in_reset("rst");
    #10 rst_n = 1'b1;
    align();

    for (int n = 0; n < 300; n++) begin gen(25);  step(); end
    for (int n = 0; n < 300; n++) begin gen(100); step(); end
    for (int n = 0; n < 400; n++) begin gen(60);  step(); end

    guard = 0;
    while ((c_pend || d_pend) && guard < 20) begin gen(0); step(); guard++; end
    check("drain_timeout", 64'(c_pend || d_pend), 64'h0);
    c_pend = 0;
    d_pend = 0;
    drive();
    for (int n = 0; n < 3; n++) step();

    // reset arriving while a full-word write is on the memory port
    c_cur.we    = 1'b1;
    c_cur.addr  = 9'h0A5;
    c_cur.wdata = 32'h1234_5678;
    c_cur.be    = 4'hF;
    c_pend      = 1;
    drive();
    step();
    #2;
    check("mid_access_mem_wr", bus.mem_wr, 4'hF);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    check_gnt_in_reset("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    align();
    model_reset();
    for (int n = 0; n < 5; n++) begin gen(0); step(); end

    for (int n = 0; n < 300; n++) begin gen(50); step(); end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

- Shares the single data-memory port between two requesters: the core load/store path (port 0) and the DMA/debug engine (port 1).
- Core has fixed priority. An aging counter guarantees the DMA a grant after a bounded wait.
- Each accepted request is registered onto the word-addressed memory port (address, write data, 4-bit byte write strobe), then acknowledged with a response pulse carrying read data.
- Sits between the load/store unit, the DMA engine and the data memory.

## Interface
Parameters:
- DM_ADDRESS, 9, byte-address width of the data memory
- DATA_W, 32, data width
- DMA_MAX_WAIT, 4, number of lost arbitration cycles after which the DMA wins

Ports (clock and reset first):
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- c_req  in  1  core request; held high until c_gnt
- c_we  in  1  core write (1) / read (0)
- c_addr  in  DM_ADDRESS  core byte address
- c_wdata  in  DATA_W  core write data, already lane-aligned
- c_be  in  4  core byte enables
- c_gnt  out  1  core request accepted this cycle
- c_rvalid  out  1  core response pulse
- c_rdata  out  DATA_W  core read word
- d_req, d_we, d_addr, d_wdata, d_be, d_gnt, d_rvalid, d_rdata: same as the core signals, for the DMA port
- mem_addr  out  DM_ADDRESS  word-aligned address: {addr[DM_ADDRESS-1:2],2'b00}
- mem_wdata  out  DATA_W  write data to memory
- mem_wr  out  4  byte write strobes; nonzero only in ACCESS
- mem_rdata  in  DATA_W  memory read word for mem_addr

## Operation
- States:
  - IDLE: no access in flight.
  - ACCESS: memory cycle in progress.
  - RESP: response cycle; also arbitrates.
- Arbitration happens in IDLE and RESP only. In ACCESS, c_gnt = d_gnt = 0.
- Winner selection:
  - Only one requester active: that requester wins.
  - Both active and dma_wait == DMA_MAX_WAIT: DMA wins.
  - Both active otherwise: core wins.
- Grant: gnt is combinational from state and req, asserted for exactly one cycle.
  - Granted request fields are registered into mem_addr and mem_wdata.
  - Strobes are latched as be if we=1, else 4'b0000.
  - Granted port ID is latched. Next state is ACCESS.
- ACCESS:
  - mem_wr drives the latched strobes for exactly one cycle.
  - mem_rdata is captured into the latched port's rdata register at the end of the cycle.
  - Next state is RESP.
- RESP:
  - Latched port's rvalid = 1 for one cycle.
  - rdata is the captured word for reads and 0 for writes.
  - The other port's rvalid = 0 and its rdata holds its previous value.
  - Next state is ACCESS if a grant is issued, else IDLE.
- Aging counter dma_wait:
  - Range 0..DMA_MAX_WAIT.
  - Increments, saturating, each cycle d_req = 1 and d_gnt = 0 (ACCESS cycles included).
  - Cleared when d_gnt = 1.
- Edge cases:
  - A write with be = 0000 is a legal no-op write; it is still granted and acknowledged.
  - Misaligned address bits addr[1:0] are dropped on mem_addr. Lane selection and sign extension stay in the requester.

## Timing
- Reset (async, rst_n = 0):
  - State → IDLE, dma_wait → 0.
  - mem_addr, mem_wdata, mem_wr, c_rvalid, d_rvalid, c_rdata and d_rdata all go to 0 immediately.
  - c_gnt and d_gnt are 0 while reset is asserted.
- Reset mid-ACCESS: mem_wr drops asynchronously and the in-flight access is lost. No response is issued after release.
- Latency: gnt in cycle N, mem_wr/read in N+1, rvalid in N+2.
- Throughput: back-to-back grants from RESP give one access per 2 cycles.
- Requester rules:
  - Must hold req and all fields stable until gnt.
  - May deassert req the cycle after gnt.
  - May issue its next request while awaiting rvalid; that request is granted no earlier than the RESP cycle.
- Simultaneous c_req/d_req in RESP follow the same winner selection as IDLE.

## Test plan
- Core-only read: mem_rdata = 0xDEADBEEF at addr 0x014, c_req read addr 0x016 → c_gnt at N, mem_addr = 0x014 and mem_wr = 0000 at N+1, c_rvalid and c_rdata = 0xDEADBEEF at N+2.
- Byte write: DMA write addr 0x103, be = 1000, wdata = 0xAB000000 → mem_wr = 1000 for exactly one cycle at N+1, d_rvalid at N+2 with d_rdata = 0.
- Contention/aging, DMA_MAX_WAIT = 4:
  - Stimulus: both requesters held continuously.
  - Core wins until dma_wait reaches 4, then d_gnt = 1.
  - dma_wait returns to 0 and the next contention grant goes to the core.
- Back-to-back: core issues a new request during RESP → c_gnt in that RESP cycle, ACCESS follows immediately, with no IDLE cycle between.
- Reset mid-ACCESS: assert rst_n = 0 while mem_wr = 1111 → mem_wr = 0 without waiting for a clock edge. After release, no rvalid appears and state is IDLE.
- Zero-strobe write (be = 0000) → mem_wr stays 0000 and rvalid still pulses at N+2.
